// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and FIFO helper types for the receive-side buffer.
// Receiver, transmitter and rx FIFO all import this package.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int RX_FIFO_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_sel_e;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the rx FIFO: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Write port: store the incoming byte on an accepted push.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with fill flags and sticky overflow.
// Optional build macro UART_RX_FIFO_DROP_CNT_EN adds a saturating dropped-byte counter (drop_cnt).
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH     = RX_FIFO_DEPTH_DEF,
    parameter int AW        = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic [AW:0] level,
    output logic        empty,
    output logic        full,
    output logic        almost_full,
    output logic        overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
    output logic [7:0]  drop_cnt,
`endif
    input  logic        clr_ovf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          overflow_q, overflow_d;
    logic          push_s, pop_s, drop_s;
    logic          empty_s, full_s;
    logic [7:0]    mem_rdata_s;
    fifo_op_e      op_s;

    assign empty_s = (level_q == {(AW+1){1'b0}});
    assign full_s  = (level_q == DEPTH_C);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte.
    assign pop_s  = !empty_s && m_ready;
    assign push_s = rx_valid && (!full_s || pop_s);
    assign drop_s = rx_valid && full_s && !pop_s;
    assign op_s   = fifo_op_e'({push_s, pop_s});

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (UART_DATA_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_s)
    );

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        case (op_s)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                level_d  = level_q + (AW+1)'(1);
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                level_d  = level_q - (AW+1)'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
                level_d = level_q;
            end
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            level_q    <= {(AW+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // A drop in the clearing cycle is counted after the clear.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_ovf) begin
            drop_cnt_d = drop_s ? 8'h01 : 8'h00;
        end else if (drop_s) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'h00;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign m_valid     = !empty_s;
    assign m_data      = empty_s ? 8'h00 : mem_rdata_s;
    assign level       = level_q;
    assign empty       = empty_s;
    assign full        = full_s;
    assign almost_full = (level_q >= AFULL_C);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; a byte-queue reference tracks
// expected order, level and overflow.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       m_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       m_valid, empty, full, almost_full, overflow;
    logic [7:0] m_data;
    logic [4:0] level;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic [7:0] drop_m = 8'h00;
`endif

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] model_q[$];
    logic       ovf_m = 1'b0;

    always #10 clk = ~clk;

    uart_rx_fifo dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .clr_ovf     (clr_ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock with the given inputs; model updated in lockstep, outputs checked #1 after the edge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
        logic pop_m, push_m, drop;
        rx_valid = v; rx_data = d; m_ready = r; clr_ovf = c;
        pop_m  = r && (model_q.size() > 0);
        push_m = v && (model_q.size() < 16 || pop_m);
        drop   = v && (model_q.size() == 16) && !pop_m;
        if (pop_m) check_eq("head", {24'd0, m_data}, {24'd0, model_q[0]});
        @(posedge clk); #1;
        rx_valid = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
        if (pop_m) void'(model_q.pop_front());
        if (push_m) model_q.push_back(d);
        if (drop) ovf_m = 1'b1;
        else if (c) ovf_m = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
        if (c) drop_m = drop ? 8'h01 : 8'h00;
        else if (drop && drop_m != 8'hFF) drop_m = drop_m + 8'd1;
`endif
        check_eq("level", {27'd0, level}, model_q.size());
        check_eq("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    endtask

    task automatic drain_all();
        for (int k = 0; k < 20 && model_q.size() > 0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("drain_empty", {31'd0, empty}, 32'd1);
        check_eq("drain_mdata", {24'd0, m_data}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_mvalid"}, {31'd0, m_valid}, 32'd0);
        check_eq({tag, "_mdata"}, {24'd0, m_data}, 32'd0);
        check_eq({tag, "_empty"}, {31'd0, empty}, 32'd1);
        check_eq({tag, "_full"}, {31'd0, full}, 32'd0);
        check_eq({tag, "_afull"}, {31'd0, almost_full}, 32'd0);
        check_eq({tag, "_level"}, {27'd0, level}, 32'd0);
        check_eq({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check_eq({tag, "_dropcnt"}, {24'd0, drop_cnt}, 32'd0);
`endif
    endtask

    initial begin
        // Reset state
        #5;
        check_reset_outputs("rst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte fall-through and pop
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check_eq("t1_mvalid", {31'd0, m_valid}, 32'd1);
        check_eq("t1_mdata", {24'd0, m_data}, 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t1_empty", {31'd0, empty}, 32'd1);
        check_eq("t1_mdata0", {24'd0, m_data}, 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("t1_ready_empty", {27'd0, level}, 32'd0);

        // Fill 0x00..0x0F, almost_full from the 12th push
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0);
            check_eq("t2_afull", {31'd0, almost_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
            check_eq("t2_full", {31'd0, full}, (i == 15) ? 32'd1 : 32'd0);
        end
        drain_all();

        // Overflow while full, then clear, then clear racing a new drop
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        check_eq("t3_ovf", {31'd0, overflow}, 32'd1);
        check_eq("t3_full", {31'd0, full}, 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t3_clr", {31'd0, overflow}, 32'd0);
        cycle(1'b1, 8'h78, 1'b0, 1'b1);
        check_eq("t3_setwins", {31'd0, overflow}, 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check_eq("t6_drop_clr_race", {24'd0, drop_cnt}, 32'h01);
`endif
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Full with simultaneous push and pop: accepted, no overflow
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check_eq("t4_level", {27'd0, level}, 32'd16);
        check_eq("t4_ovf", {31'd0, overflow}, 32'd0);
        check_eq("t4_tail", {24'd0, model_q[15]}, 32'h55);
        drain_all();

        // Interleaved traffic wrapping the pointers
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'h80 + 8'(i), (i % 4) != 0, 1'b0);
        drain_all();

`ifdef UART_RX_FIFO_DROP_CNT_EN
        // Saturating drop counter
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        check_eq("t6_sat", {24'd0, drop_cnt}, 32'hFF);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        check_eq("t6_clr_drop", {24'd0, drop_cnt}, {24'd0, drop_m});
        drain_all();
`endif

        // Asynchronous reset mid-fill discards everything
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #2;
        model_q.delete();
        ovf_m = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
        drop_m = 8'h00;
`endif
        check_reset_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        check_eq("post_rst_mdata", {24'd0, m_data}, 32'h3C);
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
